// File: rtl/cpu_pkg.sv
// Shared execute-stage types: multiply/divide opcodes, FSM states and the
// result-select code of the iterative multiply/divide unit.
package cpu_pkg;

    typedef enum logic [1:0] {
        MD_MUL  = 2'b00,
        MD_MULH = 2'b01,
        MD_DIV  = 2'b10,
        MD_REM  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } muldiv_state_t;

    // Input of the 8-way execute result mux driven by muldiv_iter.
    localparam logic [2:0] EX_SEL_MULDIV = 3'd5;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
// acc holds {high, low}: product/multiplier for MUL, remainder/quotient for DIV.
module muldiv_step #(
    parameter int N = 32
) (
    input  logic           is_div_i,
    input  logic [2*N-1:0] acc_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] acc_o
);

    logic [N:0]   mul_sum;
    logic [N:0]   rem_shift;
    logic         rem_ge;
    logic [N-1:0] rem_trial;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        acc_o     = '0;
        mul_sum   = {1'b0, acc_i[2*N-1:N]} + (acc_i[0] ? {1'b0, b_i} : '0);
        rem_shift = {acc_i[2*N-1:N], acc_i[N-1]};
        rem_ge    = rem_shift >= {1'b0, b_i};
        // When the trial succeeds the difference is below b, so N bits hold it exactly.
        rem_trial = rem_shift[N-1:0] - b_i;
        if (is_div_i) begin
            acc_o = {(rem_ge ? rem_trial : rem_shift[N-1:0]), acc_i[N-2:0], rem_ge};
        end else begin
            acc_o = {mul_sum, acc_i[N-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit, one bit per cycle, start/busy/done handshake.
// Define MULDIV_SIGNED_EN to add the sgn port and the signed FIXUP pass.
module muldiv_iter
    import cpu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
`ifdef MULDIV_SIGNED_EN
    input  logic         sgn,
`endif
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         div_zero
);

    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    muldiv_state_t  state_q;
    muldiv_op_t     op_q;
    logic [CW-1:0]  cnt_q;
    logic [2*N-1:0] acc_q;
    logic [N-1:0]   b_q;
    logic           busy_q;
    logic           done_q;
    logic           div_zero_q;
    logic [N-1:0]   result_q;

    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic [2*N-1:0] step_acc;
    logic [2*N-1:0] fin_acc;
    logic           is_div;
    logic           last_iter;
    logic           finish;
    muldiv_state_t  after_run;

    function automatic logic [N-1:0] pick(input muldiv_op_t o, input logic [2*N-1:0] x);
        return (o == MD_MULH || o == MD_REM) ? x[2*N-1:N] : x[N-1:0];
    endfunction

    assign is_div    = (op_q == MD_DIV) || (op_q == MD_REM);
    assign last_iter = (state_q == RUN) && (cnt_q == LAST);

    muldiv_step #(.N(N)) u_step (
        .is_div_i (is_div),
        .acc_i    (acc_q),
        .b_i      (b_q),
        .acc_o    (step_acc)
    );

`ifdef MULDIV_SIGNED_EN
    logic           sgn_q;
    logic           qneg_q;
    logic           rneg_q;
    logic           sa;
    logic           sb;
    logic [2*N-1:0] fix_acc;

    // The core iterates on magnitudes; FIXUP restores the signs afterwards.
    assign sa    = sgn & a[N-1];
    assign sb    = sgn & b[N-1];
    assign a_mag = sa ? -a : a;
    assign b_mag = sb ? -b : b;

    always_ff @(posedge clk) begin
        if (rst) begin
            sgn_q  <= 1'b0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            sgn_q  <= sgn;
            qneg_q <= sa ^ sb;
            rneg_q <= sa;
        end
    end

    always_comb begin
        fix_acc = acc_q;
        if (is_div) begin
            if (qneg_q) fix_acc[N-1:0]   = -acc_q[N-1:0];
            if (rneg_q) fix_acc[2*N-1:N] = -acc_q[2*N-1:N];
        end else if (qneg_q) begin
            fix_acc = -acc_q;
        end
    end

    assign after_run = sgn_q ? FIXUP : DONE;
    assign fin_acc   = (state_q == FIXUP) ? fix_acc : step_acc;
    assign finish    = (state_q == FIXUP) || (last_iter && !sgn_q);
`else
    assign a_mag     = a;
    assign b_mag     = b;
    assign after_run = DONE;
    assign fin_acc   = step_acc;
    assign finish    = last_iter;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= MD_MUL;
            cnt_q      <= '0;
            acc_q      <= '0;
            b_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            result_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q  <= muldiv_op_t'(op);
                        cnt_q <= '0;
                        acc_q <= {{N{1'b0}}, a_mag};
                        b_q   <= b_mag;
                        if (op[1] && b == '0) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            div_zero_q <= 1'b1;
                            result_q   <= op[0] ? a : '1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    acc_q <= step_acc;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) state_q <= after_run;
                end
`ifdef MULDIV_SIGNED_EN
                FIXUP:   state_q <= DONE;
`endif
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (finish) begin
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                div_zero_q <= 1'b0;
                result_q   <= pick(op_q, fin_acc);
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: vector table plus reset/overlap sequences.
// Signed vectors are added when MULDIV_SIGNED_EN is defined.
module tb_muldiv_iter;
    import cpu_pkg::*;

    localparam int N   = 32;
    localparam int LAT = N + 1;
`ifdef MULDIV_SIGNED_EN
    localparam int SLAT = N + 2;
`endif

    typedef struct {
        muldiv_op_t   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         sgn;
        logic [N-1:0] res;
        logic         dz;
        int           lat;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    muldiv_op_t   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sgn;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         div_zero;

    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    muldiv_iter #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
`ifdef MULDIV_SIGNED_EN
        .sgn      (sgn),
`endif
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .div_zero (div_zero)
    );

    task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Start one operation, scramble the operand inputs after acceptance, and
    // measure the done cycle relative to the accepting edge.
    task automatic run_vec(input vec_t v, input string name);
        int cyc;
        @(negedge clk);
        start = 1'b1;
        op    = v.op;
        a     = v.a;
        b     = v.b;
        sgn   = v.sgn;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~v.a;
        b     = v.b ^ 32'h5A5A_0F0F;
        cyc   = 1;
        check({name, " busy_c1"}, {31'b0, busy}, (v.lat > 1) ? 32'd1 : 32'd0);
        while (!done && cyc < 4 * N) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({name, " done_cycle"}, cyc, v.lat);
        check({name, " result"}, result, v.res);
        check({name, " div_zero"}, {31'b0, div_zero}, {31'b0, v.dz});
        check({name, " busy_at_done"}, {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check({name, " done_pulse"}, {31'b0, done}, 32'd0);
        check({name, " result_hold"}, result, v.res);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int ndone;
        int done_cyc;

        rst   = 1'b1;
        start = 1'b0;
        op    = MD_MUL;
        a     = '0;
        b     = '0;
        sgn   = 1'b0;

        vecs.push_back('{MD_MUL,  32'h0000_FFFF, 32'h0001_0001, 1'b0, 32'hFFFF_FFFF, 1'b0, LAT});
        vecs.push_back('{MD_MULH, 32'h0000_FFFF, 32'h0001_0001, 1'b0, 32'h0000_0000, 1'b0, LAT});
        vecs.push_back('{MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b0, LAT});
        vecs.push_back('{MD_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 1'b0, LAT});
        vecs.push_back('{MD_MULH, 32'h8000_0000, 32'h0000_0002, 1'b0, 32'h0000_0001, 1'b0, LAT});
        vecs.push_back('{MD_DIV,  32'd100,       32'd7,         1'b0, 32'd14,        1'b0, LAT});
        vecs.push_back('{MD_REM,  32'd100,       32'd7,         1'b0, 32'd2,         1'b0, LAT});
        vecs.push_back('{MD_DIV,  32'd5,         32'd9,         1'b0, 32'd0,         1'b0, LAT});
        vecs.push_back('{MD_REM,  32'd5,         32'd9,         1'b0, 32'd5,         1'b0, LAT});
        vecs.push_back('{MD_DIV,  32'h0000_1234, 32'h0,         1'b0, 32'hFFFF_FFFF, 1'b1, 1});
        vecs.push_back('{MD_REM,  32'h0000_1234, 32'h0,         1'b0, 32'h0000_1234, 1'b1, 1});
        vecs.push_back('{MD_MUL,  32'd3,         32'd4,         1'b0, 32'd12,        1'b0, LAT});
        vecs.push_back('{MD_DIV,  32'hDEAD_BEEF, 32'd1,         1'b0, 32'hDEAD_BEEF, 1'b0, LAT});
        vecs.push_back('{MD_REM,  32'hDEAD_BEEF, 32'd1,         1'b0, 32'd0,         1'b0, LAT});
        vecs.push_back('{MD_DIV,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1,         1'b0, LAT});
        vecs.push_back('{MD_DIV,  32'hFFFF_FFFF, 32'd2,         1'b0, 32'h7FFF_FFFF, 1'b0, LAT});
        vecs.push_back('{MD_REM,  32'hFFFF_FFFF, 32'd2,         1'b0, 32'd1,         1'b0, LAT});
`ifdef MULDIV_SIGNED_EN
        vecs.push_back('{MD_DIV,  32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 1'b0, SLAT});
        vecs.push_back('{MD_REM,  32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFF, 1'b0, SLAT});
        vecs.push_back('{MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b0, SLAT});
        vecs.push_back('{MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0,         1'b0, SLAT});
        vecs.push_back('{MD_MUL,  32'hFFFF_FFFD, 32'd4,         1'b1, 32'hFFFF_FFF4, 1'b0, SLAT});
        vecs.push_back('{MD_MULH, 32'hFFFF_FFFD, 32'd4,         1'b1, 32'hFFFF_FFFF, 1'b0, SLAT});
        vecs.push_back('{MD_REM,  32'hFFFF_FFFB, 32'h0,         1'b1, 32'hFFFF_FFFB, 1'b1, 1});
        vecs.push_back('{MD_DIV,  32'd100,       32'd7,         1'b0, 32'd14,        1'b0, LAT});
`endif

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset div_zero", {31'b0, div_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Starts while busy and in the done cycle are dropped; cycle 34 start is taken.
        @(negedge clk);
        start = 1'b1;
        op    = MD_MUL;
        a     = 32'd3;
        b     = 32'd4;
        sgn   = 1'b0;
        @(posedge clk);
        #1;
        start    = 1'b0;
        cyc      = 1;
        ndone    = 0;
        done_cyc = 0;
        while (cyc <= LAT + 1) begin
            if (done) begin
                ndone++;
                done_cyc = cyc;
                check("overlap result", result, 32'd12);
            end
            @(negedge clk);
            start = 1'b0;
            if (cyc == 5) begin
                start = 1'b1; op = MD_DIV; a = 32'd100; b = 32'd7;
            end else if (cyc == LAT) begin
                start = 1'b1; op = MD_MUL; a = 32'd5; b = 32'd5;
            end else if (cyc == LAT + 1) begin
                start = 1'b1; op = MD_MUL; a = 32'd5; b = 32'd6;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        check("overlap done_count", ndone, 32'd1);
        check("overlap done_cycle", done_cyc, LAT);
        cyc = 1;
        while (!done && cyc < 4 * N) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("restart done_cycle", cyc, LAT);
        check("restart result", result, 32'd30);

        // Reset in cycle 10 of a multiply kills it without a done pulse.
        @(negedge clk);
        start = 1'b1;
        op    = MD_MUL;
        a     = 32'h0000_FFFF;
        b     = 32'h0001_0001;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrun busy", {31'b0, busy}, 32'd0);
        check("midrun done", {31'b0, done}, 32'd0);
        check("midrun result", result, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        repeat (LAT + 8) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("midrun no_done", ndone, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
